id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the register file. Captures ReadData1/ReadData2, immediate, PC, register indices and decoded control each cycle, and presents them to the EX stage.
- Contains load-use hazard detection, which stalls IF/ID and injects a bubble.
- Contains a write-back bypass, because the register file writes at posedge and reads combinationally, so a same-cycle write is not visible to a read.
- Contains flush handling for taken branches.

Parameters:
- XLEN, 64, datapath width
- REG_AW, 5, register index width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- id_pc  in  XLEN  PC of instruction in ID
- id_rd1  in  XLEN  ReadData1 from register file
- id_rd2  in  XLEN  ReadData2 from register file
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REG_AW each  register indices
- id_ctrl  in  9  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp[1:0], valid}
- id_funct  in  4  {instr[30], funct3}
- wb_regwrite  in  1  WB-stage write enable
- wb_rd  in  REG_AW  WB destination
- wb_data  in  XLEN  WB write data
- flush  in  1  taken-branch flush from EX/MEM
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN  registered operands
- ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered indices
- ex_ctrl  out  9  registered control
- ex_funct  out  4  registered funct
- stall  out  1  hold PC and IF/ID (combinational)

Behaviour:
- Reset (reset=0, async): all ex_* outputs are 0 and the FSM goes to RUN. stall is 0 while reset is asserted.
- Latency: 1 cycle. Values present in ID at posedge N appear on ex_* after posedge N.

WB bypass (combinational, before capture):
- op1 = wb_data if wb_regwrite && wb_rd!=0 && wb_rd==id_rs1; otherwise op1 = id_rd1.
- op2 is formed the same way from id_rs2 and id_rd2.
- x0 is never bypassed.

Hazard detection (combinational):
- hz = ex_ctrl.MemRead && ex_ctrl.valid && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2) && id_ctrl.valid.
- stall = hz && state==RUN && !flush.

FSM states: RUN, BUBBLE.
- RUN and hz and !flush: capture a bubble (ex_ctrl=0 and ex_rd=0; data fields don't-care but zeroed), then go to BUBBLE.
- BUBBLE: capture normally (the instruction was held by stall), stall=0, then go to RUN. A second consecutive hazard is impossible because ex_ctrl was zeroed.
- RUN and no hazard: capture normally.

Flush and simultaneous events:
- flush=1 in any state: capture a bubble and go to RUN. Flush has priority over hazard and stall, so stall=0 during flush.
- A bypass and a hazard on the same cycle: the bubble is still inserted. The bypass applies when the held instruction is captured.

Width and reset rules:
- No arithmetic; all fields are passed at full width.
- Reset asserted mid-stall clears all fields and the FSM immediately. After deassertion the first capture is normal.

Optional Feature:
- Macro: ID_EX_STATS_EN.
- When defined:
  - Adds output stall_cnt (32 bits) and output flush_cnt (32 bits).
  - stall_cnt increments on each posedge where stall=1.
  - flush_cnt increments on each posedge where flush=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When undefined: these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset held low with id_* nonzero -> all ex_* are 0 and stall=0. After release, id_rd1=0x15, id_rs1=3 appear on ex_rd1=0x15, ex_rs1=3 one cycle later.
- Bypass: id_rs1=5, id_rd1=0x6, wb_regwrite=1, wb_rd=5, wb_data=0xDEAD -> ex_rd1=0xDEAD. Repeat with wb_rd=0 and id_rs1=0 -> ex_rd1=id_rd1.
- Load-use: the EX instruction is a load with ex_rd=8, and ID has id_rs2=8 -> stall=1 for exactly 1 cycle and ex_ctrl=0 next cycle. On the following cycle the ID instruction is captured with stall=0.
- Flush during hazard: the load-use condition and flush=1 occur together -> stall=0, ex_ctrl=0, and the FSM stays in RUN.
- Load with ex_rd=0 and id_rs1=0 -> no stall.
- ID_EX_STATS_EN: 3 load-use hazards and 2 flushes -> stall_cnt=3 and flush_cnt=2. Asserting reset clears both to 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use stall/bubble and branch flush.
// Defining ID_EX_STATS_EN adds saturating stall_cnt/flush_cnt event counters.
module id_ex_stage #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rd1,
   input  logic [XLEN-1:0]   id_rd2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [8:0]        id_ctrl,
   input  logic [3:0]        id_funct,
   input  logic              wb_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rd1,
   output logic [XLEN-1:0]   ex_rd2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [8:0]        ex_ctrl,
   output logic [3:0]        ex_funct,
`ifdef ID_EX_STATS_EN
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt,
`endif
   output logic              stall
);

   // Control vector: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp[1:0], valid}
   localparam int CtrlMemRead = 7;
   localparam int CtrlValid   = 0;

   typedef enum logic [0:0] {StRun, StBubble} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, rd1_q, rd2_q, imm_q;
   logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
   logic [8:0]        ctrl_q;
   logic [3:0]        funct_q;
   logic [XLEN-1:0]   op1, op2;
   logic              hz, bubble;

   // The register file cannot see a write landing on this same edge, so forward it here.
   always_comb begin
      op1 = id_rd1;
      op2 = id_rd2;
      if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs1)) op1 = wb_data;
      if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs2)) op2 = wb_data;
   end

   assign hz = ctrl_q[CtrlMemRead] && ctrl_q[CtrlValid] && (rd_q != '0) &&
               ((rd_q == id_rs1) || (rd_q == id_rs2)) && id_ctrl[CtrlValid];

   assign stall  = hz && (state_q == StRun) && !flush;
   assign bubble = flush || stall;

   always_comb begin
      state_d = StRun;
      if (stall) state_d = StBubble;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StRun;
         pc_q    <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         ctrl_q  <= '0;
         funct_q <= '0;
      end else begin
         state_q <= state_d;
         if (bubble) begin
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            funct_q <= '0;
         end else begin
            pc_q    <= id_pc;
            rd1_q   <= op1;
            rd2_q   <= op2;
            imm_q   <= id_imm;
            rs1_q   <= id_rs1;
            rs2_q   <= id_rs2;
            rd_q    <= id_rd;
            ctrl_q  <= id_ctrl;
            funct_q <= id_funct;
         end
      end
   end

   assign ex_pc    = pc_q;
   assign ex_rd1   = rd1_q;
   assign ex_rd2   = rd2_q;
   assign ex_imm   = imm_q;
   assign ex_rs1   = rs1_q;
   assign ex_rs2   = rs2_q;
   assign ex_rd    = rd_q;
   assign ex_ctrl  = ctrl_q;
   assign ex_funct = funct_q;

`ifdef ID_EX_STATS_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cases with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of the ID/EX register.
module tb_id_ex_stage;

   logic        clk, reset;
   logic [63:0] id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [8:0]  id_ctrl;
   logic [3:0]  id_funct;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        flush;
   logic [63:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [8:0]  ex_ctrl;
   logic [3:0]  ex_funct;
   logic        stall;
`ifdef ID_EX_STATS_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   id_ex_stage #(.XLEN(64), .REG_AW(5)) dut (
      .clk(clk), .reset(reset),
      .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl), .id_funct(id_funct),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
      .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_funct(ex_funct),
`ifdef ID_EX_STATS_EN
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
      .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what EX holds, and whether the ID instruction is being held.
   typedef struct packed {
      logic [63:0] pc, rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [8:0]  ctrl;
      logic [3:0]  funct;
   } ex_t;

   ex_t         m_ex;
   logic        m_held;
   logic [31:0] m_scnt, m_fcnt;
   logic        m_stall;

   // Load in EX writing a register the valid ID instruction reads, unless flushed or already held.
   assign m_stall = reset && !flush && !m_held && m_ex.ctrl[7] && m_ex.ctrl[0] &&
                    (m_ex.rd != 5'd0) && id_ctrl[0] &&
                    ((m_ex.rd == id_rs1) || (m_ex.rd == id_rs2));

   function automatic logic [63:0] fwd(input logic [4:0] rs, input logic [63:0] rf_val);
      if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs)) return wb_data;
      return rf_val;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ex   <= '0;
         m_held <= 1'b0;
         m_scnt <= '0;
         m_fcnt <= '0;
      end else begin
         if (m_stall && m_scnt != 32'hFFFF_FFFF) m_scnt <= m_scnt + 1;
         if (flush && m_fcnt != 32'hFFFF_FFFF) m_fcnt <= m_fcnt + 1;
         m_held <= m_stall;
         if (flush || m_stall) m_ex <= '0;
         else m_ex <= '{pc: id_pc, rd1: fwd(id_rs1, id_rd1), rd2: fwd(id_rs2, id_rd2),
                        imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                        ctrl: id_ctrl, funct: id_funct};
      end
   end

   always @(negedge clk) begin
      cmp("ex_pc", ex_pc, m_ex.pc);
      cmp("ex_rd1", ex_rd1, m_ex.rd1);
      cmp("ex_rd2", ex_rd2, m_ex.rd2);
      cmp("ex_imm", ex_imm, m_ex.imm);
      cmp("ex_rs1", 64'(ex_rs1), 64'(m_ex.rs1));
      cmp("ex_rs2", 64'(ex_rs2), 64'(m_ex.rs2));
      cmp("ex_rd", 64'(ex_rd), 64'(m_ex.rd));
      cmp("ex_ctrl", 64'(ex_ctrl), 64'(m_ex.ctrl));
      cmp("ex_funct", 64'(ex_funct), 64'(m_ex.funct));
      cmp("stall", 64'(stall), 64'(m_stall));
`ifdef ID_EX_STATS_EN
      cmp("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
      cmp("flush_cnt", 64'(flush_cnt), 64'(m_fcnt));
`endif
   end

   task automatic next_drive();
      @(posedge clk);
      #2;
   endtask

   task automatic set_id(input logic [63:0] pc, input logic [63:0] rd1, input logic [63:0] rd2,
                         input logic [63:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [8:0] ctrl, input logic [3:0] funct);
      id_pc = pc; id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = ctrl; id_funct = funct;
   endtask

   task automatic set_wb(input logic we, input logic [4:0] rd, input logic [63:0] data);
      wb_regwrite = we; wb_rd = rd; wb_data = data;
   endtask

   localparam logic [8:0] Load = 9'h1B1;  // RegWrite, MemRead, MemtoReg, ALUSrc, valid
   localparam logic [8:0] Alu  = 9'h101;  // RegWrite, valid
   localparam logic [8:0] Nop  = 9'h001;

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      set_wb(1'b0, 5'd0, 64'd0);
      set_id(64'h0, 64'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0, 9'h0, 4'h0);
      #1 reset = 1'b0;
      set_id(64'hAAAA, 64'h1234, 64'h5678, 64'h9ABC, 5'd5, 5'd6, 5'd5, 9'h1FF, 4'hF);
      @(negedge clk);
      @(negedge clk);
      cmp("rst ex_pc", ex_pc, 64'h0);
      cmp("rst ex_rd1", ex_rd1, 64'h0);
      cmp("rst ex_ctrl", 64'(ex_ctrl), 64'h0);
      cmp("rst stall", 64'(stall), 64'h0);
      reset = 1'b1;

      next_drive();
      set_id(64'h100, 64'h15, 64'h0, 64'h0, 5'd3, 5'd0, 5'd1, Nop, 4'h0);
      @(negedge clk);
      cmp("first stall", 64'(stall), 64'h0);

      next_drive();
      set_id(64'h104, 64'h6, 64'h7, 64'h0, 5'd5, 5'd6, 5'd2, Nop, 4'h0);
      set_wb(1'b1, 5'd5, 64'hDEAD);
      @(negedge clk);
      cmp("first ex_rd1", ex_rd1, 64'h15);
      cmp("first ex_rs1", 64'(ex_rs1), 64'd3);

      next_drive();
      set_id(64'h108, 64'h6, 64'h7, 64'h0, 5'd0, 5'd0, 5'd3, Nop, 4'h0);
      set_wb(1'b1, 5'd0, 64'hBEEF);
      @(negedge clk);
      cmp("bypass rs1", ex_rd1, 64'hDEAD);
      cmp("bypass rs2 none", ex_rd2, 64'h7);

      next_drive();
      set_id(64'h10C, 64'h0, 64'h0, 64'h10, 5'd1, 5'd2, 5'd8, Load, 4'h0);
      set_wb(1'b0, 5'd0, 64'h0);
      @(negedge clk);
      cmp("x0 no bypass", ex_rd1, 64'h6);

      next_drive();
      set_id(64'h110, 64'h111, 64'h222, 64'h0, 5'd4, 5'd8, 5'd9, Alu, 4'h8);
      @(negedge clk);
      cmp("load ex_rd", 64'(ex_rd), 64'd8);
      cmp("load-use stall", 64'(stall), 64'h1);

      next_drive();
      @(negedge clk);
      cmp("bubble ex_ctrl", 64'(ex_ctrl), 64'h0);
      cmp("bubble stall", 64'(stall), 64'h0);

      next_drive();
      set_id(64'h114, 64'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0, Nop, 4'h0);
      @(negedge clk);
      cmp("held ex_ctrl", 64'(ex_ctrl), 64'(Alu));
      cmp("held ex_rd2", ex_rd2, 64'h222);
      cmp("held ex_funct", 64'(ex_funct), 64'h8);

      next_drive();
      set_id(64'h118, 64'h0, 64'h0, 64'h0, 5'd1, 5'd2, 5'd8, Load, 4'h0);
      next_drive();
      set_id(64'h11C, 64'h111, 64'h222, 64'h0, 5'd8, 5'd3, 5'd9, Alu, 4'h0);
      flush = 1'b1;
      @(negedge clk);
      cmp("flush+hz stall", 64'(stall), 64'h0);

      next_drive();
      flush = 1'b0;
      @(negedge clk);
      cmp("flush ex_ctrl", 64'(ex_ctrl), 64'h0);

      next_drive();
      set_id(64'h120, 64'h0, 64'h0, 64'h0, 5'd1, 5'd2, 5'd8, Load, 4'h0);
      next_drive();
      set_id(64'h124, 64'h0, 64'h0, 64'h0, 5'd8, 5'd0, 5'd9, Alu, 4'h0);
      @(negedge clk);
      cmp("run after flush", 64'(stall), 64'h1);

      next_drive();
      set_id(64'h128, 64'h0, 64'h0, 64'h0, 5'd1, 5'd2, 5'd0, Load, 4'h0);
      next_drive();
      set_id(64'h12C, 64'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd4, Alu, 4'h0);
      @(negedge clk);
      cmp("x0 load ex_rd", 64'(ex_rd), 64'h0);
      cmp("x0 load stall", 64'(stall), 64'h0);

      for (int i = 0; i < 3000; i++) begin
         next_drive();
         reset = ($urandom_range(0, 199) != 0);
         if (!m_held) begin
            set_id({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 9'($urandom), 4'($urandom));
            id_ctrl[0] = ($urandom_range(0, 7) != 0);
            id_ctrl[7] = 1'($urandom_range(0, 1));
         end
         set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), {$urandom, $urandom});
         flush = ($urandom_range(0, 9) == 0);
      end
      next_drive();
      reset = 1'b1;
      flush = 1'b0;
      set_wb(1'b0, 5'd0, 64'h0);

`ifdef ID_EX_STATS_EN
      set_id(64'h0, 64'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0, Nop, 4'h0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         next_drive();
         set_id(64'h200, 64'h0, 64'h0, 64'h0, 5'd1, 5'd2, 5'd8, Load, 4'h0);
         next_drive();
         set_id(64'h204, 64'h0, 64'h0, 64'h0, 5'd8, 5'd0, 5'd9, Alu, 4'h0);
         next_drive();
         next_drive();
         set_id(64'h208, 64'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0, Nop, 4'h0);
      end
      for (int k = 0; k < 2; k++) begin
         next_drive();
         flush = 1'b1;
         next_drive();
         flush = 1'b0;
      end
      @(negedge clk);
      cmp("stall_cnt=3", 64'(stall_cnt), 64'd3);
      cmp("flush_cnt=2", 64'(flush_cnt), 64'd2);
      reset = 1'b0;
      #1;
      cmp("stall_cnt rst", 64'(stall_cnt), 64'd0);
      cmp("flush_cnt rst", 64'(flush_cnt), 64'd0);
      #1 reset = 1'b1;
`endif

      next_drive();
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
